// File: rtl/mips_ifetch_unit.sv
// Instruction-fetch unit for the multicycle MIPS core: assembles a little-endian
// 32-bit instruction from 32/BUSW bus beats with wait states, timeout and redirect.
module mips_ifetch_unit #(
  parameter int              AW       = 8,
  parameter int              BUSW     = 8,
  parameter logic [AW-1:0]   RESET_PC = '0,
  parameter int              MAXWAIT  = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_req,
  input  logic            redirect_en,
  input  logic [AW-1:0]   redirect_pc,
  output logic            mem_rd,
  output logic [AW-1:0]   mem_adr,
  input  logic [BUSW-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic [31:0]     instr,
  output logic            instr_valid,
  output logic [AW-1:0]   instr_pc,
  output logic [AW-1:0]   pc_next,
  output logic            busy,
  output logic            fetch_err
);

  localparam int BEATS = 32 / BUSW;
  localparam int STEP  = BUSW / 8;
  localparam int BTW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WCW   = (MAXWAIT > 0) ? $clog2(MAXWAIT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE
  } state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   base;
  logic [BTW-1:0]  beat;
  logic [WCW-1:0]  wcnt;
  logic [31:0]     shadow;
  logic [31:0]     assembled;
  logic            err_q;
  logic [AW-1:0]   redir_al;
  logic [AW-1:0]   target;
  logic            last_beat;
  logic            timeout;

  assign redir_al  = redirect_pc & ~AW'(3);
  assign target    = redirect_en ? redir_al : pc_next;
  assign last_beat = (int'(beat) == BEATS - 1);
  assign timeout   = (MAXWAIT != 0) && !mem_ready && (int'(wcnt) + 1 == MAXWAIT);
  assign fetch_err = err_q;

  // Shadow with the current beat merged in, so the completing beat can land
  // straight in instr without exposing partial data.
  always_comb begin
    assembled = shadow;
    assembled[int'(beat)*BUSW +: BUSW] = mem_rdata;
  end

  always_comb begin
    mem_adr = pc_next;
    if (state == FETCH) begin
      mem_adr = base + AW'(int'(beat) * STEP);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    mem_rd      = 1'b0;
    busy        = 1'b0;
    instr_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (fetch_req) state_nx = FETCH;
      end
      FETCH: begin
        mem_rd = 1'b1;
        busy   = 1'b1;
        if (redirect_en) begin
          state_nx = IDLE;
        end else if (mem_ready && last_beat) begin
          state_nx = DONE;
        end else if (timeout) begin
          state_nx = IDLE;
        end
      end
      DONE: begin
        instr_valid = 1'b1;
        state_nx    = fetch_req ? FETCH : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // instr/instr_pc/pc_next are loaded on the edge entering DONE so they are
  // already valid during the instr_valid cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base     <= RESET_PC;
      beat     <= '0;
      wcnt     <= '0;
      shadow   <= '0;
      instr    <= '0;
      instr_pc <= '0;
      pc_next  <= RESET_PC;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          pc_next <= target;
          if (fetch_req) begin
            base <= target;
            beat <= '0;
            wcnt <= '0;
          end
        end
        FETCH: begin
          if (redirect_en) begin
            pc_next <= redir_al;
          end else if (mem_ready) begin
            shadow <= assembled;
            wcnt   <= '0;
            if (last_beat) begin
              instr    <= assembled;
              instr_pc <= base;
              pc_next  <= base + AW'(4);
            end else begin
              beat <= beat + BTW'(1);
            end
          end else begin
            wcnt <= wcnt + WCW'(1);
            if (timeout) err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
